// File: rtl/dvp_rgb565_tx.sv
// DVP (OV5640-style) RGB565 source: vsync/href/8-bit bus, high byte first, fed from a
// valid/ready pixel stream or an internal 8-bar colour pattern.
module dvp_rgb565_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 288,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned VSYNC_LINES = 4,
    parameter int unsigned V_BACK      = 16,
    parameter int unsigned V_FRONT     = 8
) (
    input  logic        i_cmos_pclk,
    input  logic        i_rst,
    input  logic        i_tx_en,
    input  logic        i_pattern_en,
    input  logic [15:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic        o_cmos_vsync,
    output logic        o_cmos_href,
    output logic [7:0]  o_cmos_d,
    output logic        o_frame_done,
    output logic        o_underflow,
    input  logic        i_underflow_clr
);
    localparam int unsigned H_TOTAL     = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL     = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW          = $clog2(H_TOTAL);
    localparam int unsigned VW          = $clog2(V_TOTAL);
    localparam int unsigned BAR_W       = H_ACTIVE / 8;
    localparam int unsigned BW          = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned V_ACT_START = VSYNC_LINES + V_BACK;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          r_state, w_state_nxt;
    logic [HW-1:0]   r_h_cnt, w_h_nxt;
    logic [VW-1:0]   r_v_cnt, w_v_nxt;
    logic            r_pat;
    logic            r_href;
    logic            r_vsync;
    logic            r_frame_done;
    logic [7:0]      r_d;
    logic [7:0]      r_lo_byte;
    logic            r_underflow;
    logic [BW-1:0]   r_bar_px;
    logic [2:0]      r_bar;

    logic            w_run;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_vs_reg;
    logic            w_act_line;
    logic            w_act;
    logic            w_frame_start;
    logic            w_pat;
    logic            w_fetch;
    logic [15:0]     w_bar_rgb;
    logic [15:0]     w_pixel;

    assign w_run         = (r_state == StRun);
    assign w_h_last      = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last      = (r_v_cnt == VW'(V_TOTAL - 1));
    assign w_vs_reg      = (32'(r_v_cnt) < VSYNC_LINES);
    assign w_act_line    = (32'(r_v_cnt) >= V_ACT_START) && (32'(r_v_cnt) < V_ACT_END);
    assign w_act         = w_run && w_act_line && (32'(r_h_cnt) < 2 * H_ACTIVE);
    assign w_frame_start = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    // Source select takes effect from the very first cycle of the frame.
    assign w_pat         = w_frame_start ? i_pattern_en : r_pat;
    assign w_fetch       = w_act && !r_h_cnt[0] && !w_pat;

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        case (r_state)
            StIdle: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (i_tx_en) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_h_last) begin
                    w_h_nxt = '0;
                    if (w_v_last) begin
                        w_v_nxt = '0;
                        if (!i_tx_en) begin
                            w_state_nxt = StIdle;
                        end
                    end else begin
                        w_v_nxt = r_v_cnt + VW'(1);
                    end
                end else begin
                    w_h_nxt = r_h_cnt + HW'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_bar_rgb = 16'h0000;
        case (r_bar)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'h07FF;
            3'd3:    w_bar_rgb = 16'h07E0;
            3'd4:    w_bar_rgb = 16'hF81F;
            3'd5:    w_bar_rgb = 16'hF800;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    assign w_pixel = w_pat ? w_bar_rgb : (i_pix_valid ? i_pix_data : 16'h0000);

    always_ff @(posedge i_cmos_pclk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_pat        <= 1'b0;
            r_href       <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b0;
            r_d          <= 8'h00;
            r_lo_byte    <= 8'h00;
            r_underflow  <= 1'b0;
            r_bar_px     <= '0;
            r_bar        <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_h_cnt      <= w_h_nxt;
            r_v_cnt      <= w_v_nxt;
            r_href       <= w_act;
            r_vsync      <= w_run && w_vs_reg;
            r_frame_done <= w_run && w_h_last && w_v_last;
            if (w_frame_start) begin
                r_pat <= i_pattern_en;
            end

            // Even byte slot emits the high byte and parks the low byte for the odd slot.
            if (w_act) begin
                if (!r_h_cnt[0]) begin
                    r_d       <= w_pixel[15:8];
                    r_lo_byte <= w_pixel[7:0];
                end else begin
                    r_d <= r_lo_byte;
                end
            end else begin
                r_d <= 8'h00;
            end

            if (!w_act) begin
                r_bar_px <= '0;
                r_bar    <= 3'd0;
            end else if (r_h_cnt[0]) begin
                if (r_bar_px == BW'(BAR_W - 1)) begin
                    r_bar_px <= '0;
                    r_bar    <= r_bar + 3'd1;
                end else begin
                    r_bar_px <= r_bar_px + BW'(1);
                end
            end

            if (w_fetch && !i_pix_valid) begin
                r_underflow <= 1'b1;
            end else if (i_underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_pix_ready  = w_fetch;
    assign o_cmos_vsync = r_vsync;
    assign o_cmos_href  = r_href;
    assign o_cmos_d     = r_d;
    assign o_frame_done = r_frame_done;
    assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Scoreboard bench for dvp_rgb565_tx: expected bytes are queued as pixels are issued and
// popped by a monitor on every href byte; frame timing is checked against fixed constants.
module tb_dvp_rgb565_tx;
    localparam int unsigned H_ACTIVE    = 8;
    localparam int unsigned H_BLANK     = 6;
    localparam int unsigned V_ACTIVE    = 4;
    localparam int unsigned VSYNC_LINES = 1;
    localparam int unsigned V_BACK      = 1;
    localparam int unsigned V_FRONT     = 1;
    localparam int          FRAME       = 154;

    logic        clk           = 1'b0;
    logic        rst           = 1'b1;
    logic        tx_en         = 1'b0;
    logic        pattern_en    = 1'b0;
    logic [15:0] pix_data      = 16'h0000;
    logic        pix_valid     = 1'b1;
    logic        underflow_clr = 1'b0;
    logic        pix_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;
    logic        underflow;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          fetch_cnt = 0;
    int          pix_idx   = 0;
    int          href_run  = 0;
    int          vs_run    = 0;
    logic        in_rst    = 1'b1;
    logic        fr_valid  = 1'b0;
    logic        fr_pat    = 1'b0;
    logic        drop_arm  = 1'b0;
    logic        drop_clr  = 1'b0;
    logic        clr_req   = 1'b0;
    logic [7:0]  eb;
    logic [7:0]  exp_q[$];
    logic [7:0]  pat_bytes[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                   8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    dvp_rgb565_tx #(
        .H_ACTIVE   (H_ACTIVE),
        .H_BLANK    (H_BLANK),
        .V_ACTIVE   (V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES),
        .V_BACK     (V_BACK),
        .V_FRONT    (V_FRONT)
    ) dut (
        .i_cmos_pclk    (clk),
        .i_rst          (rst),
        .i_tx_en        (tx_en),
        .i_pattern_en   (pattern_en),
        .i_pix_data     (pix_data),
        .i_pix_valid    (pix_valid),
        .o_pix_ready    (pix_ready),
        .o_cmos_vsync   (vsync),
        .o_cmos_href    (href),
        .o_cmos_d       (d),
        .o_frame_done   (frame_done),
        .o_underflow    (underflow),
        .i_underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pattern_frame();
        for (int l = 0; l < int'(V_ACTIVE); l++) begin
            for (int b = 0; b < 16; b++) exp_q.push_back(pat_bytes[b]);
        end
    endtask

    task automatic start_book();
        fr_pat    = pattern_en;
        fr_valid  = 1'b1;
        fetch_cnt = 0;
        if (fr_pat) push_pattern_frame();
    endtask

    task automatic check_quiet(input string name);
        check(name, int'({pix_ready, vsync, href, frame_done, underflow, d}), 0);
    endtask

    task automatic wait_fd(output int c);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 400);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got none, expected a pulse within 400 cycles");
        end
        c = cyc;
    endtask

    // n is the cycle count at the negedge where the FSM first sees tx_en=1 out of IDLE.
    task automatic check_start(input int n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!vsync && k < 200);
        check("vsync_rise_cycle", cyc - n, 2);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!href && k < 200);
        check("first_href_cycle", cyc - n, 46);
    endtask

    // Stream driver: issues the next pixel whenever the DUT fetches, queueing its bytes.
    always @(negedge clk) begin
        underflow_clr = clr_req;
        clr_req       = 1'b0;
        pix_valid     = 1'b1;
        if (!in_rst && pix_ready) begin
            if (drop_arm && fetch_cnt == 3) begin
                pix_valid = 1'b0;
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
                drop_arm = 1'b0;
                if (drop_clr) begin
                    underflow_clr = 1'b1;
                    drop_clr      = 1'b0;
                end
            end else begin
                pix_data = 16'h0100 + 16'(pix_idx);
                exp_q.push_back(pix_data[15:8]);
                exp_q.push_back(pix_data[7:0]);
                pix_idx++;
            end
            fetch_cnt++;
        end
    end

    // Monitor: pops one expected byte per href cycle and checks line/frame structure.
    always @(negedge clk) begin
        if (in_rst) begin
            exp_q.delete();
            href_run  = 0;
            vs_run    = 0;
            fetch_cnt = 0;
            fr_valid  = 1'b0;
        end else begin
            if (href) begin
                href_run++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected: got 0x%02h, expected no href", d);
                end else begin
                    eb = exp_q.pop_front();
                    check("href_byte", int'(d), int'(eb));
                end
            end else begin
                check("d_outside_href", int'(d), 0);
                if (href_run != 0) begin
                    check("href_line_len", href_run, 16);
                    href_run = 0;
                end
            end
            if (vsync) begin
                vs_run++;
            end else if (vs_run != 0) begin
                check("vsync_len", vs_run, 22);
                vs_run = 0;
            end
            if (frame_done) begin
                if (fr_valid) begin
                    check("frame_queue_empty", exp_q.size(), 0);
                    check("frame_fetches", fetch_cnt, fr_pat ? 0 : 32);
                end
                fetch_cnt = 0;
                if (tx_en) begin
                    fr_pat   = pattern_en;
                    fr_valid = 1'b1;
                    if (fr_pat) push_pattern_frame();
                end else begin
                    fr_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int c1;
        int c2;
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        in_rst = 1'b0;
        check_quiet("idle_no_tx_en");

        // Stream mode, back-to-back frames.
        @(negedge clk);
        tx_en = 1'b1;
        n     = cyc;
        start_book();
        check_start(n);
        wait_fd(c1);
        check("first_frame_done", c1 - n, FRAME + 1);
        wait_fd(c2);
        check("frame_period", c2 - c1, FRAME);

        // Mid-frame pattern_en toggles only apply from the next frame start.
        repeat (30) @(negedge clk);
        pattern_en = 1'b1;
        wait_fd(c1);
        repeat (30) @(negedge clk);
        pattern_en = 1'b0;
        wait_fd(c2);
        check("pattern_frame_period", c2 - c1, FRAME);

        // Drop pixel 3 of line 0: fill bytes, sticky underflow, then clear.
        check("underflow_before_drop", int'(underflow), 0);
        drop_arm = 1'b1;
        wait_fd(c1);
        check("underflow_set", int'(underflow), 1);
        repeat (40) @(negedge clk);
        check("underflow_sticky", int'(underflow), 1);
        clr_req = 1'b1;
        repeat (2) @(negedge clk);
        check("underflow_cleared", int'(underflow), 0);

        // Set and clear in the same cycle: set must win.
        wait_fd(c1);
        drop_arm = 1'b1;
        drop_clr = 1'b1;
        wait_fd(c2);
        check("drop_frame_period", c2 - c1, FRAME);
        check("underflow_set_beats_clr", int'(underflow), 1);
        clr_req = 1'b1;
        repeat (2) @(negedge clk);
        check("underflow_cleared_again", int'(underflow), 0);

        // Drop tx_en at frame cycle 60: the frame completes, then IDLE.
        wait_fd(c1);
        repeat (60) @(negedge clk);
        tx_en = 1'b0;
        wait_fd(c2);
        check("stop_frame_period", c2 - c1, FRAME);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_quiet("idle_after_stop");
        end
        tx_en = 1'b1;
        n     = cyc;
        start_book();
        check_start(n);
        wait_fd(c1);
        check("restart_frame_done", c1 - n, FRAME + 1);

        // Synchronous reset at frame cycle 70 with tx_en held high.
        repeat (70) @(negedge clk);
        rst    = 1'b1;
        in_rst = 1'b1;
        @(negedge clk);
        check_quiet("midframe_reset_outputs");
        rst = 1'b0;
        n   = cyc;
        @(negedge clk);
        in_rst = 1'b0;
        start_book();
        check_start(n);
        wait_fd(c1);
        check("post_reset_frame_done", c1 - n, FRAME + 1);
        wait_fd(c2);
        check("post_reset_period", c2 - c1, FRAME);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
